starfield_layers: RTL and testbench

- Parametrised multi-layer parallax star-field generator for the 640x480 VGA pipeline; sits beside the vga timing block and feeds a 3-bit rgb mux.
- Each of LAYERS planes owns an LFSR that is restarted from a per-layer seed every frame, so stars are stationary within a frame.
- Between frames each seed is advanced by a layer-dependent number of LFSR steps, scrolling the planes at different speeds (far = slow).
- Output is registered, with nearest-layer priority.

---
 rtl/starfield_layers_pkg.sv | 23 ++
 rtl/starfield_layers_lfsr.sv | 30 +++
 rtl/starfield_layers.sv | 164 ++++++++++++++++
 tb/tb_starfield_layers.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/starfield_layers_pkg.sv
// Shared definitions for the parallax star-field generator.
//   - default feedback taps and layer colours
//   - first vertical-blanking line number for 640x480
//   - ADVANCE step counter width
//   - FSM state encoding
package starfield_layers_pkg;

    localparam logic [15:0] SF_DEF_TAPS         = 16'b1000000001011;
    localparam logic [8:0]  SF_DEF_LAYER_COLORS = {3'b111, 3'b011, 3'b001};
    localparam int          SF_V_ACTIVE         = 480;

    // A 16-bit counter is enough because LAYERS*SPEED must stay below 36000.
    // That bound also keeps ADVANCE+LOAD inside one vertical blanking
    // interval (45 lines x 800 clocks).
    localparam int          SF_CNT_W            = 16;

    typedef enum logic [1:0] {
        SF_IDLE    = 2'd0,
        SF_ADVANCE = 2'd1,
        SF_LOAD    = 2'd2
    } sf_state_t;

endpackage

// File: rtl/starfield_layers_lfsr.sv
// Fibonacci-style shift-left LFSR with synchronous load.
//   clk, reset (async, active low, restores INIT)
//   step       : advance one position
//   load       : replace value with load_value (wins over step)
//   load_value : value loaded when load=1
//   value      : current register contents
module starfield_lfsr #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'h100B),
    parameter logic [LFSR_W-1:0] INIT   = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= INIT;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= {value[LFSR_W-2:0], ^(value & TAPS)};
        end
    end

endmodule

// File: rtl/starfield_layers.sv
// Multi-layer parallax star-field generator for the 640x480 VGA pipeline.
//   clk, reset  : system clock, async active-low reset
//   hpos, vpos  : raster position from the vga timing block
//   display_on  : active-video flag
//   scroll_en   : 1 = seeds advance at the frame boundary, 0 = field frozen
//   rgb         : colour of the nearest star, 0 otherwise (one cycle latency)
//   star_on     : a star is drawn this pixel
//   layer_id    : winning layer index, 0 when no star
//
// Each layer has a seed LFSR (advanced between frames) and a pixel LFSR
// (reloaded from the seed every frame and stepped on every active pixel).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | drawing / waiting for the frame boundary
// ADVANCE | stepping seed l while cnt < (l+1)*SPEED
// LOAD    | one cycle: every pixel LFSR takes its seed
module starfield_layers
    import starfield_layers_pkg::*;
#(
    parameter int                    LAYERS       = 3,
    parameter int                    LFSR_W       = 16,
    parameter logic [LFSR_W-1:0]     TAPS         = LFSR_W'(SF_DEF_TAPS),
    parameter int                    DENSITY_BITS = 7,
    parameter int                    SPEED        = 1,
    parameter int                    V_ACTIVE     = SF_V_ACTIVE,
    parameter logic [3*LAYERS-1:0]   LAYER_COLORS = (3*LAYERS)'(SF_DEF_LAYER_COLORS)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       scroll_en,
    output logic [2:0] rgb,
    output logic       star_on,
    output logic [1:0] layer_id
);

    localparam logic [SF_CNT_W-1:0] CNT_LAST = SF_CNT_W'(LAYERS*SPEED - 1);

    sf_state_t              state_q, state_d;
    logic [SF_CNT_W-1:0]    cnt_q, cnt_d;
    logic [LAYERS-1:0]      seed_step;
    logic                   pix_load;
    logic                   frame_bnd;

    logic [LFSR_W-1:0]      seed_val [LAYERS];
    logic [LFSR_W-1:0]      pix_val  [LAYERS];
    logic [LAYERS-1:0]      star;

    logic                   win_found;
    logic [1:0]             win_id;
    logic [2:0]             win_rgb;

    assign frame_bnd = !display_on && (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        starfield_lfsr #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .INIT   (LFSR_W'(l + 1))
        ) u_seed (
            .clk        (clk),
            .reset      (reset),
            .step       (seed_step[l]),
            .load       (1'b0),
            .load_value ('0),
            .value      (seed_val[l])
        );

        starfield_lfsr #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .INIT   (LFSR_W'(l + 1))
        ) u_pix (
            .clk        (clk),
            .reset      (reset),
            .step       (display_on),
            .load       (pix_load),
            .load_value (seed_val[l]),
            .value      (pix_val[l])
        );

        // Star when the top DENSITY_BITS of the pre-step value are all ones.
        assign star[l] = &pix_val[l][LFSR_W-1 -: DENSITY_BITS];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_step = '0;
        pix_load  = 1'b0;
        unique case (state_q)
            SF_IDLE: begin
                cnt_d = '0;
                if (frame_bnd) begin
                    state_d = scroll_en ? SF_ADVANCE : SF_LOAD;
                end
            end
            SF_ADVANCE: begin
                // Nearer layers stay enabled longer, so they scroll faster.
                for (int l = 0; l < LAYERS; l++) begin
                    seed_step[l] = (cnt_q < SF_CNT_W'((l + 1) * SPEED));
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = SF_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            SF_LOAD: begin
                pix_load = 1'b1;
                state_d  = SF_IDLE;
            end
            default: begin
                state_d = SF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ascending scan: the highest-numbered (nearest) layer overrides.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        win_rgb   = 3'b000;
        for (int l = 0; l < LAYERS; l++) begin
            if (star[l]) begin
                win_found = 1'b1;
                win_id    = 2'(l);
                win_rgb   = LAYER_COLORS[3*l +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb      <= 3'b000;
            star_on  <= 1'b0;
            layer_id <= 2'd0;
        end else if (display_on && win_found) begin
            rgb      <= win_rgb;
            star_on  <= 1'b1;
            layer_id <= win_id;
        end else begin
            rgb      <= 3'b000;
            star_on  <= 1'b0;
            layer_id <= 2'd0;
        end
    end

endmodule

// File: tb/tb_starfield_layers.sv
// Directed bench for starfield_layers (LAYERS=3, LFSR_W=16, SPEED=1).
module tb_starfield_layers;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       scroll_en = 1'b0;
    logic [2:0] rgb;
    logic       star_on;
    logic [1:0] layer_id;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_seed [3];
    logic [15:0] m_lfsr [3];
    logic [2:0]  frame_cur [$];
    logic [2:0]  frame_a   [$];
    logic [2:0]  frame_b   [$];

    always #5 clk = ~clk;

    starfield_layers dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .scroll_en  (scroll_en),
        .rgb        (rgb),
        .star_on    (star_on),
        .layer_id   (layer_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], ^(v & 16'h100B)};
    endfunction

    function automatic logic [2:0] color(input int l);
        case (l)
            0:       return 3'b001;
            1:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // {star_on, layer_id, rgb} expected one cycle after a sample
    function automatic logic [5:0] model_out(input logic disp);
        logic [5:0] r;
        r = '0;
        if (disp) begin
            for (int l = 0; l < 3; l++) begin
                if (&m_lfsr[l][15:9]) r = {1'b1, 2'(l), color(l)};
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] dut_out();
        return {star_on, layer_id, rgb};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 3; l++) begin
            m_seed[l] = 16'(l + 1);
            m_lfsr[l] = 16'(l + 1);
        end
    endtask

    task automatic model_step();
        for (int l = 0; l < 3; l++) m_lfsr[l] = nxt(m_lfsr[l]);
    endtask

    // First cycle index at which two or more layers light the same active pixel.
    function automatic int find_overlap(input int limit);
        logic [15:0] v [3];
        int hits;
        for (int l = 0; l < 3; l++) v[l] = m_lfsr[l];
        for (int i = 0; i < limit; i++) begin
            if ((i % 16) != 15) begin
                hits = 0;
                for (int l = 0; l < 3; l++) if (&v[l][15:9]) hits++;
                if (hits >= 2) return i;
                for (int l = 0; l < 3; l++) v[l] = nxt(v[l]);
            end
        end
        return -1;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic run_frame(input int n);
        logic       disp;
        logic [5:0] exp;
        frame_cur.delete();
        for (int i = 0; i < n; i++) begin
            disp       = ((i % 16) != 15);
            display_on = disp;
            hpos       = 10'(i % 640);
            vpos       = 10'd5;
            exp        = model_out(disp);
            @(posedge clk); #1;
            chk("pixel", 32'(dut_out()), 32'(exp));
            frame_cur.push_back(rgb);
            if (disp) model_step();
        end
    endtask

    task automatic boundary(input logic scroll);
        display_on = 1'b0;
        hpos       = 10'd0;
        vpos       = 10'd480;
        scroll_en  = scroll;
        @(posedge clk); #1;
        hpos = 10'd1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("blank_out", 32'(dut_out()), 32'd0);
        end
        for (int l = 0; l < 3; l++) begin
            if (scroll) for (int s = 0; s <= l; s++) m_seed[l] = nxt(m_seed[l]);
            m_lfsr[l] = m_seed[l];
        end
    endtask

    initial begin
        int n1;
        int ov;
        int mism;
        int guard;
        logic found;
        logic [5:0] exp;

        model_reset();

        // reset asserted
        #12;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_star_on", 32'(star_on), 32'd0);
        chk("rst_layer_id", 32'(layer_id), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_out", 32'(dut_out()), 32'd0);
        chk("rel_state", 32'(dut.state_q), 32'd0);
        chk("rel_cnt", 32'(dut.cnt_q), 32'd0);
        chk("rel_lfsr0", 32'(dut.pix_val[0]), 32'h0001);
        chk("rel_lfsr1", 32'(dut.pix_val[1]), 32'h0002);
        chk("rel_lfsr2", 32'(dut.pix_val[2]), 32'h0003);
        chk("rel_seed2", 32'(dut.seed_val[2]), 32'h0003);

        // two active pixels, then hold
        display_on = 1'b1;
        @(posedge clk); #1;
        chk("step1_lfsr0", 32'(dut.pix_val[0]), 32'h0003);
        chk("step1_lfsr1", 32'(dut.pix_val[1]), 32'h0005);
        chk("step1_rgb", 32'(rgb), 32'd0);
        @(posedge clk); #1;
        chk("step2_lfsr0", 32'(dut.pix_val[0]), 32'h0006);
        chk("step2_lfsr1", 32'(dut.pix_val[1]), 32'h000B);
        display_on = 1'b0;
        @(posedge clk); #1;
        chk("hold_lfsr0", 32'(dut.pix_val[0]), 32'h0006);
        model_step();
        model_step();

        // frame boundary with scroll, scroll_en dropped mid-ADVANCE,
        // boundary held so it is also seen outside IDLE
        hpos = 10'd0; vpos = 10'd480; scroll_en = 1'b1;
        @(posedge clk); #1;
        chk("adv_state0", 32'(dut.state_q), 32'd1);
        chk("adv_seed0_a", 32'(dut.seed_val[0]), 32'h0001);
        scroll_en = 1'b0;
        @(posedge clk); #1;
        chk("adv_state1", 32'(dut.state_q), 32'd1);
        chk("adv_seed0_b", 32'(dut.seed_val[0]), 32'h0003);
        chk("adv_seed1_b", 32'(dut.seed_val[1]), 32'h0005);
        chk("adv_seed2_b", 32'(dut.seed_val[2]), 32'h0006);
        @(posedge clk); #1;
        chk("adv_state2", 32'(dut.state_q), 32'd1);
        chk("adv_seed0_c", 32'(dut.seed_val[0]), 32'h0003);
        chk("adv_seed1_c", 32'(dut.seed_val[1]), 32'h000B);
        chk("adv_seed2_c", 32'(dut.seed_val[2]), 32'h000D);
        @(posedge clk); #1;
        chk("load_state", 32'(dut.state_q), 32'd2);
        chk("load_seed1", 32'(dut.seed_val[1]), 32'h000B);
        chk("load_seed2", 32'(dut.seed_val[2]), 32'h001A);
        hpos = 10'd1;
        @(posedge clk); #1;
        chk("idle_state", 32'(dut.state_q), 32'd0);
        chk("loaded_lfsr0", 32'(dut.pix_val[0]), 32'h0003);
        chk("loaded_lfsr1", 32'(dut.pix_val[1]), 32'h000B);
        chk("loaded_lfsr2", 32'(dut.pix_val[2]), 32'h001A);
        @(posedge clk); #1;
        chk("idle_stays", 32'(dut.state_q), 32'd0);
        m_seed[0] = 16'h0003; m_seed[1] = 16'h000B; m_seed[2] = 16'h001A;
        for (int l = 0; l < 3; l++) m_lfsr[l] = m_seed[l];

        // first frame long enough to cover a multi-layer overlap
        ov = find_overlap(40000);
        n1 = (ov >= 0 && ov + 4 > 1200) ? ov + 4 : 1200;
        run_frame(n1);

        // frozen field: two frames must match pixel for pixel
        boundary(1'b0);
        run_frame(1200);
        frame_a = frame_cur;
        boundary(1'b0);
        run_frame(1200);
        frame_b = frame_cur;
        mism = 0;
        for (int i = 0; i < 1200; i++) if (frame_a[i] !== frame_b[i]) mism++;
        chk("frozen_repeat", 32'(mism), 32'd0);

        // scrolling frame
        boundary(1'b1);
        run_frame(1200);

        // reset while a star is on the output
        found = 1'b0;
        guard = 0;
        while (!found && guard < 20000) begin
            display_on = 1'b1;
            hpos = 10'd7; vpos = 10'd5;
            exp = model_out(1'b1);
            @(posedge clk); #1;
            chk("pixel", 32'(dut_out()), 32'(exp));
            model_step();
            if (exp[5]) found = 1'b1;
            guard++;
        end
        chk("star_reached", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(dut_out()), 32'd0);
        chk("async_rst_lfsr2", 32'(dut.pix_val[2]), 32'h0003);
        display_on = 1'b0;
        hpos = 10'd1;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // reset during ADVANCE
        hpos = 10'd0; vpos = 10'd480; scroll_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_seed0", 32'(dut.seed_val[0]), 32'h0003);
        reset = 1'b0;
        #1;
        chk("adv_rst_state", 32'(dut.state_q), 32'd0);
        chk("adv_rst_seed0", 32'(dut.seed_val[0]), 32'h0001);
        chk("adv_rst_seed1", 32'(dut.seed_val[1]), 32'h0002);
        chk("adv_rst_out", 32'(dut_out()), 32'd0);
        hpos = 10'd1;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(dut.state_q), 32'd0);
        boundary(1'b1);
        chk("re_adv_seed0", 32'(dut.seed_val[0]), 32'h0003);
        chk("re_adv_seed1", 32'(dut.seed_val[1]), 32'h000B);
        chk("re_adv_seed2", 32'(dut.seed_val[2]), 32'h001A);
        chk("re_adv_lfsr2", 32'(dut.pix_val[2]), 32'h001A);
        run_frame(600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
